// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock with an on-the-fly key schedule.
// Define AES_CTRL_ABORT_EN to add an `abort` input that cancels a block in progress.
module aes128_round_ctrl #(
    parameter bit CLEAR_ON_DONE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round
`ifdef AES_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ROUND = 3'd1,
        S_FINAL = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    state_t       st;
    logic [127:0] state_reg;
    logic [127:0] rk;
    logic [127:0] next_rk;
    logic [127:0] sub_shift;
    logic [127:0] round_full;
    logic [127:0] round_final;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Byte i = r + 4c sits at [127-8i -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] sub_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rc, 24'h000000};
        n0  = k[127:96] ^ t;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign next_rk     = key_expand(rk, rcon_of(round));
    assign sub_shift   = sub_shift_rows(state_reg);
    assign round_full  = mix_columns(sub_shift) ^ next_rk;
    assign round_final = sub_shift ^ next_rk;

    assign in_ready   = (st == S_IDLE) | ((st == S_DONE) & out_ready);
    assign ciphertext = state_reg;

    // Reset beats abort, abort beats any handshake; DONE can reload in the same edge it hands off.
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            state_reg <= '0;
            rk        <= '0;
            round     <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end
`ifdef AES_CTRL_ABORT_EN
        else if (abort && (st != S_IDLE)) begin
            st        <= S_IDLE;
            state_reg <= '0;
            rk        <= '0;
            round     <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end
`endif
        else begin
            case (st)
                S_IDLE: begin
                    if (in_valid) begin
                        st        <= S_ROUND;
                        state_reg <= plaintext ^ key;
                        rk        <= key;
                        round     <= 4'd1;
                        busy      <= 1'b1;
                    end
                end
                S_ROUND: begin
                    state_reg <= round_full;
                    rk        <= next_rk;
                    round     <= round + 4'd1;
                    if (round == 4'd9) st <= S_FINAL;
                end
                S_FINAL: begin
                    state_reg <= round_final;
                    rk        <= next_rk;
                    st        <= S_DONE;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            st        <= S_ROUND;
                            state_reg <= plaintext ^ key;
                            rk        <= key;
                            round     <= 4'd1;
                            busy      <= 1'b1;
                        end else begin
                            st    <= S_IDLE;
                            round <= 4'd0;
                            if (CLEAR_ON_DONE) begin
                                state_reg <= '0;
                                rk        <= '0;
                            end
                        end
                    end
                end
                default: begin
                    st        <= S_IDLE;
                    round     <= 4'd0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: FIPS-197 vectors, handshake corner cases and
// random blocks compared against a byte-array AES model. Abort checks build with AES_CTRL_ABORT_EN.
module tb_aes128_round_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round;
`ifdef AES_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] sboxTab [256];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes128_round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
`ifdef AES_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .round      (round)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmulTb(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Textbook AES on a 4x4 byte matrix with a fully expanded 44-word key schedule.
    function automatic logic [127:0] modelEncrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  w [44];
        logic [31:0]  temp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {sboxTab[temp[23:16]], sboxTab[temp[15:8]],
                        sboxTab[temp[7:0]], sboxTab[temp[31:24]]} ^ {rc, 24'h000000};
                rc = gmulTb(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sboxTab[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gmulTb(8'h02, t[0][c]) ^ gmulTb(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmulTb(8'h02, t[1][c]) ^ gmulTb(8'h03, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmulTb(8'h02, t[2][c]) ^ gmulTb(8'h03, t[3][c]);
                    s[3][c] = gmulTb(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmulTb(8'h02, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k);
        @(negedge clk);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        checkOutput("in_ready_at_accept", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic waitOut(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1 cnt++;
        end while (!out_valid && cnt < 40);
        if (!out_valid) checkOutput("out_valid_timeout", {127'd0, out_valid}, 128'd1);
    endtask

    task automatic waitRound(input logic [3:0] r);
        int n;
        n = 0;
        while (round != r && n < 30) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("reach_round", {124'd0, round}, {124'd0, r});
    endtask

    task automatic finishBlock();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("release_round", {124'd0, round}, 128'd0);
        checkOutput("release_clear", ciphertext, 128'd0);
    endtask

    initial begin
        logic [7:0]   inv;
        logic [7:0]   sb;
        logic [7:0]   cst;
        logic [127:0] rpt;
        logic [127:0] rkey;
        logic [127:0] rexp;
        int           cnt;
        int           n;
        int           hold;
        logic         seen;

        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmulTb(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                sb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
            sboxTab[x] = sb;
        end

        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rst_busy", {127'd0, busy}, 128'd0);
        checkOutput("rst_round", {124'd0, round}, 128'd0);
        checkOutput("rst_ct", ciphertext, 128'd0);
        in_valid = 1'b0;
        reset    = 1'b0;

        $display("[TB] FIPS-197 appendix B vector");
        applyStimulus(PT_B, KEY_B);
        checkOutput("b_busy", {127'd0, busy}, 128'd1);
        checkOutput("b_round1", {124'd0, round}, 128'd1);
        waitOut(cnt);
        checkOutput("b_latency", 128'(cnt), 128'd10);
        checkOutput("b_ct", ciphertext, CT_B);
        checkOutput("b_round_done", {124'd0, round}, 128'd10);
        checkOutput("b_busy_done", {127'd0, busy}, 128'd0);
        finishBlock();

        $display("[TB] FIPS-197 C.1 vector with stalled consumer");
        out_ready = 1'b0;
        applyStimulus(PT_C, KEY_C);
        waitOut(cnt);
        checkOutput("c_ct", ciphertext, CT_C);
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("c_hold_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("c_hold_ct", ciphertext, CT_C);
        end
        finishBlock();

        $display("[TB] back-to-back blocks");
        applyStimulus(PT_B, KEY_B);
        plaintext = PT_C;
        key       = KEY_C;
        in_valid  = 1'b1;
        waitOut(cnt);
        checkOutput("b2b_first_ct", ciphertext, CT_B);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
            if (n == 1) begin
                checkOutput("b2b_drop", {127'd0, out_valid}, 128'd0);
                checkOutput("b2b_reload_round", {124'd0, round}, 128'd1);
                in_valid = 1'b0;
            end
        end while (!out_valid && n < 40);
        checkOutput("b2b_spacing", 128'(n), 128'd11);
        checkOutput("b2b_second_ct", ciphertext, CT_C);
        finishBlock();

        $display("[TB] in_valid while busy is ignored");
        applyStimulus(PT_B, KEY_B);
        waitRound(4'd4);
        @(negedge clk);
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        key       = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = 1'b1;
        checkOutput("busy_in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        waitOut(cnt);
        checkOutput("busy_ct", ciphertext, CT_B);
        finishBlock();

        $display("[TB] reset in the middle of a block");
        applyStimulus(PT_B, KEY_B);
        waitRound(4'd6);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("mrst_round", {124'd0, round}, 128'd0);
        checkOutput("mrst_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("mrst_busy", {127'd0, busy}, 128'd0);
        checkOutput("mrst_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("mrst_ct", ciphertext, 128'd0);
        applyStimulus(PT_B, KEY_B);
        waitOut(cnt);
        checkOutput("mrst_rerun_ct", ciphertext, CT_B);
        finishBlock();

`ifdef AES_CTRL_ABORT_EN
        $display("[TB] abort handling");
        applyStimulus(PT_B, KEY_B);
        waitRound(4'd3);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_round", {124'd0, round}, 128'd0);
        checkOutput("abort_busy", {127'd0, busy}, 128'd0);
        checkOutput("abort_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("abort_ct", ciphertext, 128'd0);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1 seen = seen | out_valid;
        end
        checkOutput("abort_no_valid", {127'd0, seen}, 128'd0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        checkOutput("abort_idle_ready", {127'd0, in_ready}, 128'd1);
        applyStimulus(PT_C, KEY_C);
        waitOut(cnt);
        checkOutput("abort_rerun_ct", ciphertext, CT_C);
        finishBlock();
`endif

        $display("[TB] random blocks against model");
        for (int it = 0; it < 16; it++) begin
            rpt       = {$urandom, $urandom, $urandom, $urandom};
            rkey      = {$urandom, $urandom, $urandom, $urandom};
            rexp      = modelEncrypt(rpt, rkey);
            out_ready = 1'b0;
            applyStimulus(rpt, rkey);
            waitOut(cnt);
            checkOutput("rand_latency", 128'(cnt), 128'd10);
            checkOutput("rand_ct", ciphertext, rexp);
            hold = int'($urandom_range(0, 3));
            repeat (hold) begin
                @(posedge clk);
                #1;
                checkOutput("rand_hold_valid", {127'd0, out_valid}, 128'd1);
                checkOutput("rand_hold_ct", ciphertext, rexp);
            end
            finishBlock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption engine controller: accepts one plaintext/key pair and runs one full AES round per clock over a single round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) with an on-the-fly key schedule.
- Sits between the SPI receive buffer and the SPI transmit buffer.
- Sequences round 0 (AddRoundKey only), rounds 1-9 (full round) and round 10 (no MixColumns), then holds the result until it is consumed.

Parameters:
- CLEAR_ON_DONE, 1, when 1 the state and round-key registers are zeroed on the output handshake; when 0 they keep their last value.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key present.
- in_ready  output  1  block can accept a new pair this cycle.
- plaintext  input  128  byte 0 = [127:120], column-major (FIPS-197 order).
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  128  result; equals the state register.
- busy  output  1  high in LOAD/ROUND/FINAL.
- round  output  4  current round counter (0-10).

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, round=0, ciphertext=0, round-key register=0.
- States:
  - IDLE: in_ready=1. On in_valid: state_reg<=plaintext^key, rk<=key, round<=1, go to ROUND.
  - ROUND: state_reg<=MixColumns(ShiftRows(SubBytes(state_reg)))^next_rk, where next_rk=KeyExpand(rk, rcon[round]). Then rk<=next_rk and round<=round+1. Go to FINAL when round==9 is being completed.
  - FINAL (round==10): state_reg<=ShiftRows(SubBytes(state_reg))^next_rk; go to DONE.
  - DONE: out_valid=1, ciphertext stable. On out_ready: out_valid drops next cycle and the registers are cleared per CLEAR_ON_DONE. If in_valid is also high that cycle, the new pair is loaded exactly as in IDLE.
- Latency: if the accept edge is T, out_valid is high after edge T+10. Throughput: one block per 11 cycles with back-to-back handshakes.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36 for rounds 1-10.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_valid while busy is ignored; inputs are sampled only on the accept edge, and later input changes have no effect.
- out_valid stays high in DONE until out_ready, with ciphertext unchanged (no drop, no overwrite).
- round reads 0 in IDLE, 1-10 during processing, and 10 in DONE.
- reset asserted in any state: next cycle all outputs return to reset values and the partial result is discarded. Reset wins over any simultaneous handshake.
- Unreachable state encodings return to IDLE.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- Defined: adds input port `abort` (1 bit). abort high in LOAD/ROUND/FINAL/DONE returns the FSM to IDLE next cycle, zeroes state_reg/rk/round and forces out_valid=0. abort in IDLE has no effect. abort takes priority over a same-cycle input or output handshake; reset takes priority over abort.
- Undefined: no abort port; the sequence always runs to DONE.

Test Plan:
- FIPS-197 App. B: plaintext=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid after exactly 10 edges, ciphertext=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1: plaintext=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, out_ready=0 for 5 cycles after out_valid -> ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a held stable. With CLEAR_ON_DONE=1, state reads 0 after the handshake.
- Back-to-back: App. B pair accepted, then C.1 pair presented with in_valid held high -> second accept on the same edge as the first out_ready handshake; both results correct; 11-cycle spacing between out_valid rises.
- Busy ignore: change plaintext/key and pulse in_valid at round 4 -> in_ready=0, result unchanged (3925841d...0b32).
- Mid-operation reset: assert reset at round 6 -> next cycle IDLE, round=0, out_valid=0. A new App. B run afterwards gives the correct result.
- (AES_CTRL_ABORT_EN) abort at round 3 -> IDLE next cycle, no out_valid. abort in IDLE -> no effect; a subsequent run gives the correct result.
